// File: rtl/switchless_pkg.sv
// Shared definitions for the switchless region mod: mode encodings, FSM states
// and the mode-cycling helper.
package switchless_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_USA = 2'd0;
  localparam mode_t MODE_EUR = 2'd1;
  localparam mode_t MODE_JPN = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESSED      = 3'd1,
    ST_SELECT       = 3'd2,
    ST_RESET_OUT    = 3'd3,
    ST_WAIT_RELEASE = 3'd4
  } state_e;

  // USA -> EUR -> JPN -> USA; the unused code 3 also lands on USA.
  function automatic mode_t next_mode(input mode_t m);
    if (m == MODE_JPN || m == 2'd3) begin
      return MODE_USA;
    end
    return m + 2'd1;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Clearable, enabled up-counter with a combinational terminal-count flag.
module tick_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             tc_c
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == term);

endmodule

// File: rtl/region_switch_fsm.sv
// Reset-button decoder: short press pulses the console reset, long press cycles
// and commits the region mode before resetting the console.
module region_switch_fsm
  import switchless_pkg::*;
#(
  parameter int unsigned LONG_PRESS_TICKS  = 50_000_000,
  parameter int unsigned RESET_PULSE_TICKS = 10_000_000,
  parameter logic [1:0]  DEFAULT_MODE      = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic [1:0] mode,
  output logic       video_50hz,
  output logic       region_jp,
  output logic [1:0] led_mode,
  output logic       console_reset,
  output logic       mode_changed
);

  localparam int unsigned MAX_TICKS = (LONG_PRESS_TICKS > RESET_PULSE_TICKS) ?
                                      LONG_PRESS_TICKS : RESET_PULSE_TICKS;
  localparam int unsigned CNT_W     = ($clog2(MAX_TICKS) < 1) ? 1 : $clog2(MAX_TICKS);

  localparam logic [CNT_W-1:0] LONG_TERM  = CNT_W'(LONG_PRESS_TICKS - 1);
  localparam logic [CNT_W-1:0] PULSE_TERM = CNT_W'(RESET_PULSE_TICKS - 1);

  state_e           state_q, state_d;
  mode_t            mode_q, mode_d;
  mode_t            cand_q, cand_d;
  mode_t            led_mode_q, led_mode_d;
  logic             video_50hz_q, video_50hz_d;
  logic             region_jp_q, region_jp_d;
  logic             console_reset_q, console_reset_d;
  logic             mode_changed_q, mode_changed_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_term;
  logic             cnt_tc;

  // One counter times both the hold/step period and the reset pulse.
  tick_counter #(
    .WIDTH(CNT_W)
  ) u_tick_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term),
    .tc_c (cnt_tc)
  );

  assign cnt_term = (state_q == ST_RESET_OUT) ? PULSE_TERM : LONG_TERM;

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    cand_d         = cand_q;
    mode_changed_d = 1'b0;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn) begin
          state_d = ST_PRESSED;
          cnt_clr = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn) begin
          state_d = ST_RESET_OUT;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d = ST_SELECT;
          cand_d  = next_mode(mode_q);
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_SELECT: begin
        if (!btn) begin
          mode_d         = cand_q;
          mode_changed_d = (cand_q != mode_q);
          state_d        = ST_RESET_OUT;
          cnt_clr        = 1'b1;
        end else if (cnt_tc) begin
          cand_d  = next_mode(cand_q);
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESET_OUT: begin
        if (cnt_tc) begin
          state_d = btn ? ST_WAIT_RELEASE : ST_IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!btn) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    // Outputs are decoded from next-state values so they register in step with the FSM.
    led_mode_d      = (state_d == ST_SELECT) ? cand_d : mode_d;
    console_reset_d = (state_d == ST_RESET_OUT);
    video_50hz_d    = (mode_d == MODE_EUR);
    region_jp_d     = (mode_d == MODE_JPN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mode_q          <= DEFAULT_MODE;
      cand_q          <= DEFAULT_MODE;
      led_mode_q      <= DEFAULT_MODE;
      video_50hz_q    <= (DEFAULT_MODE == MODE_EUR);
      region_jp_q     <= (DEFAULT_MODE == MODE_JPN);
      console_reset_q <= 1'b0;
      mode_changed_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      cand_q          <= cand_d;
      led_mode_q      <= led_mode_d;
      video_50hz_q    <= video_50hz_d;
      region_jp_q     <= region_jp_d;
      console_reset_q <= console_reset_d;
      mode_changed_q  <= mode_changed_d;
    end
  end

  assign mode          = mode_q;
  assign video_50hz    = video_50hz_q;
  assign region_jp     = region_jp_q;
  assign led_mode      = led_mode_q;
  assign console_reset = console_reset_q;
  assign mode_changed  = mode_changed_q;

endmodule

// File: doc/region_switch_fsm.md
# region_switch_fsm

Decodes the debounced console reset button into a console reset pulse or a region-mode change for the switchless SNES mod. It sits directly downstream of the reset-button debouncer, which supplies a clean level at 50 MHz. A short press produces a console reset. A long press cycles through the region modes while the button is held, then commits the selected mode and resets the console. Its mode outputs drive the 50/60 Hz select and region (lockout) lines, and its LED outputs drive the mode indicator.

## Interface
- `LONG_PRESS_TICKS`, 50_000_000: hold time that counts as a long press, and the step period while selecting (1 s @50 MHz).
- `RESET_PULSE_TICKS`, 10_000_000: width of the console reset pulse (200 ms @50 MHz).
- `DEFAULT_MODE`, 2'd0: mode loaded at reset.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn` in 1: debounced button level; 1 = pressed.
- `mode` out 2: committed region mode (0 USA, 1 EUR, 2 JPN; 3 never produced).
- `video_50hz` out 1: 1 when `mode`==EUR.
- `region_jp` out 1: 1 when `mode`==JPN.
- `led_mode` out 2: mode shown on the LED; the candidate in SELECT, otherwise `mode`.
- `console_reset` out 1: active-high reset to the console CPU.
- `mode_changed` out 1: one-cycle strobe when a new mode is committed.

## Operation
- States: IDLE, PRESSED, SELECT, RESET_OUT, WAIT_RELEASE.
- **IDLE:** if `btn`=1, go to PRESSED and clear `cnt`.
- **PRESSED:** on each cycle with `btn`=1, `cnt`++.
  - If `btn`=1 and `cnt`==LONG_PRESS_TICKS-1: go to SELECT, set `cand` = next(`mode`), clear `cnt`.
  - If `btn`=0: short press; go to RESET_OUT, clear `cnt`, `mode` unchanged.
- **SELECT:** `led_mode`=`cand`.
  - While `btn`=1, `cnt`++. When `cnt`==LONG_PRESS_TICKS-1, set `cand` = next(`cand`) and clear `cnt`.
  - next() wraps 0→1→2→0.
  - If `btn`=0: `mode` ← `cand`, pulse `mode_changed` (only if `cand`≠`mode`), go to RESET_OUT, clear `cnt`.
- **RESET_OUT:** `console_reset`=1, `cnt`++.
  - When `cnt`==RESET_PULSE_TICKS-1: go to WAIT_RELEASE if `btn`=1, else IDLE.
  - `btn` is ignored during the pulse.
- **WAIT_RELEASE:** go to IDLE when `btn`=0. A held button never causes a second action.
- `video_50hz` and `region_jp` are decoded from the registered `mode` and change only on commit or reset.
- Counter width is $clog2(max(LONG_PRESS_TICKS, RESET_PULSE_TICKS)). The counter never exceeds its terminal value.

## Timing
- All outputs are registered.
- Reset values:
  - `mode`=DEFAULT_MODE, `led_mode`=DEFAULT_MODE
  - `console_reset`=0, `mode_changed`=0
  - state IDLE, `cnt`=0, `cand`=DEFAULT_MODE
- `rst` mid-operation aborts any press or pulse. `console_reset` drops the next cycle, and any uncommitted candidate is discarded.
- The first cycle with `btn`=1 in IDLE is press cycle 0.
- Long press is recognised when `btn` is still 1 at press cycle LONG_PRESS_TICKS. `led_mode` shows the first candidate from the following cycle.
- `console_reset` rises the cycle after `btn`=0 is sampled in PRESSED or SELECT. It stays high for exactly RESET_PULSE_TICKS cycles.
- `mode`, `video_50hz` and `region_jp` update in the same cycle `console_reset` rises. `mode_changed` is high for that cycle only.
- A release on the exact cycle the long-press threshold is reached counts as a short press.

## Structure
- Package `switchless_pkg`:
  - mode encodings (MODE_USA/EUR/JPN)
  - state enum
  - function `next_mode()` with wrap
- Optional sub-module `tick_counter` (clear, enable, terminal-count flag), parameterised by width. One instance is shared by both timing phases.

## Test plan
All scenarios use LONG_PRESS_TICKS=8, RESET_PULSE_TICKS=4 and DEFAULT_MODE=0.
- After `rst`: `mode`=0, `video_50hz`=0, `region_jp`=0, `console_reset`=0.
- Short press: `btn` high for 3 cycles → `console_reset` high for exactly 4 cycles starting the cycle after release; `mode` stays 0; no `mode_changed`.
- Long press: `btn` held 12 cycles → `led_mode`=1 from cycle 9. On release: `mode`=1, `video_50hz`=1, one `mode_changed`, 4-cycle reset.
- Wrap: `btn` held 30 cycles → `led_mode` goes 1, 2, 0. On release: `mode`=0, no `mode_changed`, reset still pulses.
- Still held after pulse: `btn` held through the end of RESET_OUT → FSM parks in WAIT_RELEASE; no second reset or mode step until release and a new press.
- Reset mid-operation: `rst` asserted during SELECT (`led_mode`=2) and during RESET_OUT → `mode`=0, `console_reset`=0 the next cycle, FSM in IDLE.
